// File: rtl/hub75_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : hub75_scan_driver
// Purpose  : HUB75 panel scan engine with BCM colour depth, blanking and a
//            double-buffered frame swap. Define HUB75_DIMMING_EN to add a
//            global brightness input that scales the DISPLAY on-time.
// Revision : 1.0 - initial release
// ============================================================================

module hub75_scan_driver #(
    parameter int NUM_COLS       = 64,
    parameter int SCAN_RATE      = 32,
    parameter int RGB_RES        = 9,
    parameter int BASE_ON_CYCLES = 8
) (
    input  logic                                        clk_in,
    input  logic                                        rst_in,
    input  logic                                        enable,
`ifdef HUB75_DIMMING_EN
    input  logic [7:0]                                  brightness,
`endif
    input  logic                                        swap_req,
    output logic                                        swap_ack,
    output logic [$clog2(SCAN_RATE)+$clog2(NUM_COLS):0] rd_addr,
    input  logic [2*RGB_RES-1:0]                        rd_data,
    output logic [$clog2(SCAN_RATE)-1:0]                hub75_addr,
    output logic [2:0]                                  hub75_rgb0,
    output logic [2:0]                                  hub75_rgb1,
    output logic                                        hub75_latch,
    output logic                                        hub75_OE,
    output logic                                        hub75_clk,
    output logic                                        frame_done,
    output logic                                        busy
);

    localparam int c_CH_BITS = RGB_RES / 3;
    localparam int c_COL_W   = $clog2(NUM_COLS);
    localparam int c_ROW_W   = $clog2(SCAN_RATE);
    localparam int c_PLANE_W = (c_CH_BITS > 1) ? $clog2(c_CH_BITS) : 1;
    localparam int c_CNT_W   = c_COL_W + 1;
    localparam int c_MAX_ON  = BASE_ON_CYCLES << (c_CH_BITS - 1);
    localparam int c_DISP_W  = $clog2(c_MAX_ON + 1);

    localparam logic [c_CNT_W-1:0]   c_LAST_SHIFT = c_CNT_W'(2 * NUM_COLS - 1);
    localparam logic [c_ROW_W-1:0]   c_LAST_ROW   = c_ROW_W'(SCAN_RATE - 1);
    localparam logic [c_PLANE_W-1:0] c_LAST_PLANE = c_PLANE_W'(c_CH_BITS - 1);
    localparam logic [c_DISP_W-1:0]  c_BASE_ON    = c_DISP_W'(BASE_ON_CYCLES);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_PREFETCH = 3'd1;
    localparam logic [2:0] c_ST_SHIFT    = 3'd2;
    localparam logic [2:0] c_ST_LATCH    = 3'd3;
    localparam logic [2:0] c_ST_DISPLAY  = 3'd4;
    localparam logic [2:0] c_ST_BLANK    = 3'd5;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [c_ROW_W-1:0]   r_row;
    logic [c_PLANE_W-1:0] r_plane;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_DISP_W-1:0]  r_disp;
    logic                 r_buf_sel;
    logic [c_ROW_W-1:0]   r_addr;
    logic [5:0]           r_hold;

    logic                 w_last_shift;
    logic                 w_last_plane;
    logic                 w_last_row;
    logic                 w_frame_end;
    logic                 w_drive_new;
    logic [c_COL_W-1:0]   w_col_issue;
    logic [c_DISP_W-1:0]  w_base;
    logic [c_DISP_W-1:0]  w_on;
    logic [5:0]           w_bits;

    logic [c_CH_BITS-1:0] w_up_r, w_up_g, w_up_b, w_lo_r, w_lo_g, w_lo_b;

    assign w_up_b = rd_data[0 +: c_CH_BITS];
    assign w_up_g = rd_data[c_CH_BITS +: c_CH_BITS];
    assign w_up_r = rd_data[2*c_CH_BITS +: c_CH_BITS];
    assign w_lo_b = rd_data[RGB_RES +: c_CH_BITS];
    assign w_lo_g = rd_data[RGB_RES + c_CH_BITS +: c_CH_BITS];
    assign w_lo_r = rd_data[RGB_RES + 2*c_CH_BITS +: c_CH_BITS];

    assign w_bits = {w_up_r[r_plane], w_up_g[r_plane], w_up_b[r_plane],
                     w_lo_r[r_plane], w_lo_g[r_plane], w_lo_b[r_plane]};

    assign w_last_shift = (r_cnt == c_LAST_SHIFT);
    assign w_last_plane = (r_plane == c_LAST_PLANE);
    assign w_last_row   = (r_row == c_LAST_ROW);
    assign w_frame_end  = (r_state == c_ST_BLANK) && w_last_plane && w_last_row;

    // Read data for col k arrives in even shift cycle 2k; odd cycles replay the held copy.
    assign w_drive_new = (r_state == c_ST_SHIFT) && !r_cnt[0];
    assign w_col_issue = (r_state == c_ST_SHIFT) ? r_cnt[c_CNT_W-1:1] + c_COL_W'(1) : '0;

    assign rd_addr    = {r_buf_sel, r_row, w_col_issue};
    assign hub75_addr = r_addr;
    assign {hub75_rgb0, hub75_rgb1} = w_drive_new ? w_bits : r_hold;

    assign w_base = c_BASE_ON << r_plane;

`ifdef HUB75_DIMMING_EN
    logic [7:0]          r_bright;
    logic [c_DISP_W+8:0] w_prod;
    logic [c_DISP_W+8:0] w_scaled;

    assign w_prod   = (c_DISP_W+9)'(w_base) * (c_DISP_W+9)'({1'b0, r_bright} + 9'd1);
    assign w_scaled = w_prod >> 8;
    assign w_on     = (w_scaled == '0) ? c_DISP_W'(1) : w_scaled[c_DISP_W-1:0];
`else
    assign w_on = w_base;
`endif

    always_comb begin
        w_next_state = r_state;
        hub75_OE     = 1'b1;
        hub75_latch  = 1'b0;
        hub75_clk    = 1'b0;
        busy         = (r_state != c_ST_IDLE);
        frame_done   = w_frame_end;
        swap_ack     = w_frame_end && swap_req;
        case (r_state)
            c_ST_IDLE:     if (enable) w_next_state = c_ST_PREFETCH;
            c_ST_PREFETCH: w_next_state = c_ST_SHIFT;
            c_ST_SHIFT: begin
                hub75_clk = r_cnt[0];
                if (w_last_shift) w_next_state = c_ST_LATCH;
            end
            c_ST_LATCH: begin
                hub75_latch  = 1'b1;
                w_next_state = c_ST_DISPLAY;
            end
            c_ST_DISPLAY: begin
                hub75_OE = 1'b0;
                if (r_disp == '0) w_next_state = c_ST_BLANK;
            end
            c_ST_BLANK:
                w_next_state = (w_frame_end && !enable) ? c_ST_IDLE : c_ST_PREFETCH;
            default:       w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= c_ST_IDLE;
            r_row     <= '0;
            r_plane   <= '0;
            r_cnt     <= '0;
            r_disp    <= '0;
            r_buf_sel <= 1'b0;
            r_addr    <= '0;
            r_hold    <= '0;
`ifdef HUB75_DIMMING_EN
            r_bright  <= '0;
`endif
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_ST_PREFETCH: begin
                    r_cnt <= '0;
`ifdef HUB75_DIMMING_EN
                    r_bright <= brightness;
`endif
                end
                c_ST_SHIFT: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (!r_cnt[0]) r_hold <= w_bits;
                    // Row address moves on entry to LATCH, while OE is still high.
                    if (w_last_shift) r_addr <= r_row;
                end
                c_ST_LATCH:   r_disp <= w_on - c_DISP_W'(1);
                c_ST_DISPLAY: if (r_disp != '0) r_disp <= r_disp - c_DISP_W'(1);
                c_ST_BLANK: begin
                    if (w_last_plane) begin
                        r_plane <= '0;
                        r_row   <= w_last_row ? '0 : r_row + c_ROW_W'(1);
                    end else begin
                        r_plane <= r_plane + c_PLANE_W'(1);
                    end
                    if (w_frame_end && swap_req) r_buf_sel <= ~r_buf_sel;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hub75_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75_scan_driver
// Purpose  : Self-checking bench for hub75_scan_driver (4 cols, 2 row pairs,
//            2 planes, base on-time 4). Covers HUB75_DIMMING_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================

module tb_hub75_scan_driver;

    localparam int NUM_COLS       = 4;
    localparam int SCAN_RATE      = 2;
    localparam int RGB_RES        = 6;
    localparam int BASE_ON_CYCLES = 4;

    logic        clk      = 1'b0;
    logic        rst_in   = 1'b1;
    logic        enable   = 1'b0;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic [3:0]  rd_addr;
    logic [11:0] rd_data  = '0;
    logic [0:0]  hub75_addr;
    logic [2:0]  hub75_rgb0;
    logic [2:0]  hub75_rgb1;
    logic        hub75_latch;
    logic        hub75_OE;
    logic        hub75_clk;
    logic        frame_done;
    logic        busy;
`ifdef HUB75_DIMMING_EN
    logic [7:0]  brightness = 8'd255;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_run[2] = '{4, 8};

    always #5 clk = ~clk;

    hub75_scan_driver #(
        .NUM_COLS(NUM_COLS), .SCAN_RATE(SCAN_RATE),
        .RGB_RES(RGB_RES), .BASE_ON_CYCLES(BASE_ON_CYCLES)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .enable(enable),
`ifdef HUB75_DIMMING_EN
        .brightness(brightness),
`endif
        .swap_req(swap_req), .swap_ack(swap_ack),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .hub75_addr(hub75_addr), .hub75_rgb0(hub75_rgb0), .hub75_rgb1(hub75_rgb1),
        .hub75_latch(hub75_latch), .hub75_OE(hub75_OE), .hub75_clk(hub75_clk),
        .frame_done(frame_done), .busy(busy)
    );

    // Pixel store: buffer 0 = upper 10_01_11 / lower 0; buffer 1 = upper 0 / lower 11_00_10.
    function automatic logic [11:0] pix(input logic [3:0] a);
        if (a[3]) return {6'b11_00_10, 6'b00_00_00};
        return {6'b00_00_00, 6'b10_01_11};
    endfunction

    always @(posedge clk) rd_data <= pix(rd_addr);

    typedef struct {
        int         cyc;
        logic       en;
        logic       sreq;
        logic       oe;
        logic       latch;
        logic       hclk;
        logic [2:0] rgb0;
        logic [2:0] rgb1;
        logic       addr;
        logic [3:0] rda;
        logic       busy;
        logic       fd;
        logic       sack;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_vec(input string name, input vec_t v);
        logic [16:0] act, req;
        act = {hub75_OE, hub75_latch, hub75_clk, hub75_rgb0, hub75_rgb1, hub75_addr,
               rd_addr, busy, frame_done, swap_ack};
        req = {v.oe, v.latch, v.hclk, v.rgb0, v.rgb1, v.addr, v.rda, v.busy, v.fd, v.sack};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b (oe,lat,clk,rgb0,rgb1,addr,rda,busy,fd,ack)",
                     name, act, req);
        end
    endtask

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic measure_run(output int len);
        int n;
        n   = 0;
        len = 0;
        while (hub75_OE && n < 200) begin tick(); n++; end
        while (!hub75_OE && len < 200) begin tick(); len++; end
    endtask

    // Continuous invariants and OE-low run lengths (alternating plane 0 / plane 1).
    int   run = 0;
    int   pl  = 0;
    logic prev_addr = 1'b0;
    always @(negedge clk) begin
        if (rst_in) begin
            run = 0;
            pl  = 0;
        end else if (!hub75_OE) begin
            checks++;
            if (hub75_latch) begin
                errors++;
                $display("FAIL oe_latch_overlap: latch=%b while OE=%b", hub75_latch, hub75_OE);
            end
            checks++;
            if (hub75_addr != prev_addr) begin
                errors++;
                $display("FAIL addr_change_oe_low: got %0d required %0d", hub75_addr, prev_addr);
            end
            run++;
        end else if (run != 0) begin
            checks++;
            if (run != exp_run[pl]) begin
                errors++;
                $display("FAIL oe_run_plane%0d: got %0d required %0d", pl, run, exp_run[pl]);
            end
            run = 0;
            pl  = pl ^ 1;
        end
        prev_addr = hub75_addr[0];
    end

    initial begin
        vec_t rst_v;
        int   base;
        int   n;
        int   len;

        //            cyc en sr oe la ck rgb0    rgb1    a  rda      bz fd ak
        vecs[0]  = '{  0, 1, 0, 1, 0, 0, 3'b000, 3'b000, 0, 4'b0000, 1, 0, 0};
        vecs[1]  = '{  1, 1, 0, 1, 0, 0, 3'b011, 3'b000, 0, 4'b0001, 1, 0, 0};
        vecs[2]  = '{  2, 1, 0, 1, 0, 1, 3'b011, 3'b000, 0, 4'b0001, 1, 0, 0};
        vecs[3]  = '{  6, 1, 0, 1, 0, 1, 3'b011, 3'b000, 0, 4'b0011, 1, 0, 0};
        vecs[4]  = '{  9, 1, 0, 1, 1, 0, 3'b011, 3'b000, 0, 4'b0000, 1, 0, 0};
        vecs[5]  = '{ 10, 1, 0, 0, 0, 0, 3'b011, 3'b000, 0, 4'b0000, 1, 0, 0};
        vecs[6]  = '{ 13, 1, 0, 0, 0, 0, 3'b011, 3'b000, 0, 4'b0000, 1, 0, 0};
        vecs[7]  = '{ 14, 1, 0, 1, 0, 0, 3'b011, 3'b000, 0, 4'b0000, 1, 0, 0};
        vecs[8]  = '{ 15, 1, 0, 1, 0, 0, 3'b011, 3'b000, 0, 4'b0000, 1, 0, 0};
        vecs[9]  = '{ 16, 1, 0, 1, 0, 0, 3'b101, 3'b000, 0, 4'b0001, 1, 0, 0};
        vecs[10] = '{ 17, 1, 0, 1, 0, 1, 3'b101, 3'b000, 0, 4'b0001, 1, 0, 0};
        vecs[11] = '{ 25, 1, 0, 0, 0, 0, 3'b101, 3'b000, 0, 4'b0000, 1, 0, 0};
        vecs[12] = '{ 33, 1, 0, 1, 0, 0, 3'b101, 3'b000, 0, 4'b0000, 1, 0, 0};
        vecs[13] = '{ 34, 1, 0, 1, 0, 0, 3'b101, 3'b000, 0, 4'b0100, 1, 0, 0};
        vecs[14] = '{ 35, 1, 0, 1, 0, 0, 3'b011, 3'b000, 0, 4'b0101, 1, 0, 0};
        vecs[15] = '{ 43, 1, 0, 1, 1, 0, 3'b011, 3'b000, 1, 4'b0100, 1, 0, 0};
        vecs[16] = '{ 44, 1, 0, 0, 0, 0, 3'b011, 3'b000, 1, 4'b0100, 1, 0, 0};
        vecs[17] = '{ 67, 1, 0, 1, 0, 0, 3'b101, 3'b000, 1, 4'b0100, 1, 1, 0};
        vecs[18] = '{ 68, 1, 0, 1, 0, 0, 3'b101, 3'b000, 1, 4'b0000, 1, 0, 0};
        vecs[19] = '{ 77, 1, 0, 1, 1, 0, 3'b011, 3'b000, 0, 4'b0000, 1, 0, 0};
        rst_v    = '{  0, 0, 0, 1, 0, 0, 3'b000, 3'b000, 0, 4'b0000, 0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        check_vec("reset_state", rst_v);
        @(negedge clk);
        #2 rst_in = 1'b0;
        tick();
        tick();
        check_vec("idle_without_enable", rst_v);

        enable = 1'b1;
        cyc    = -1;
        tick();
        for (int i = 0; i < NV; i++) begin
            while (cyc < vecs[i].cyc) tick();
            enable   = vecs[i].en;
            swap_req = vecs[i].sreq;
            check_vec($sformatf("vec%0d_cyc%0d", i, vecs[i].cyc), vecs[i]);
        end

        // Swap requested mid-frame 1 takes effect only at its end (cycle 135).
        while (cyc < 98) tick();
        swap_req = 1'b1;
        while (cyc < 102) tick();
        check_val("buf_sel_held_mid_frame", rd_addr, 4'b0100);
        while (cyc < 135) tick();
        check_val("swap_ack_with_frame_done", {frame_done, swap_ack}, 2'b11);
        check_val("buf_sel_before_swap", rd_addr[3], 0);
        tick();
        swap_req = 1'b0;
        check_val("buf_sel_after_swap", rd_addr, 4'b1000);
        check_val("pulses_one_cycle", {frame_done, swap_ack}, 2'b00);
        tick();
        check_val("rgb_buf1_plane0", {hub75_rgb0, hub75_rgb1}, 6'b000_100);
        while (cyc < 152) tick();
        check_val("rgb_buf1_plane1", {hub75_rgb0, hub75_rgb1}, 6'b000_101);
        while (cyc < 203) tick();
        check_val("no_swap_without_req", {frame_done, swap_ack}, 2'b10);
        tick();
        check_val("buf_sel_kept", rd_addr[3], 1);

        // Enable dropped mid-frame: the frame still completes at cycle 271.
        while (cyc < 224) tick();
        enable = 1'b0;
        while (!frame_done && cyc < 400) tick();
        check_val("frame_done_after_disable", cyc, 271);
        tick();
        check_vec("idle_after_disable",
                  '{0, 0, 0, 1, 0, 0, 3'b000, 3'b101, 1, 4'b1000, 0, 0, 0});
        repeat (3) tick();
        check_val("still_idle", busy, 0);

        // Asynchronous reset during row-1 DISPLAY.
        enable = 1'b1;
        base   = cyc + 1;
        while (cyc < base + 44) tick();
        check_val("row1_display_oe", {hub75_OE, hub75_addr}, 2'b01);
        #2 rst_in = 1'b1;
        #1 check_vec("async_reset_immediate", rst_v);
        @(negedge clk);
        #2 rst_in = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!hub75_latch && n < 40);
        check_val("latch_delay_after_reset", n, 10);
        check_val("first_latch_row0", hub75_addr, 0);
        check_val("buf_sel_reset", rd_addr, 4'b0000);

`ifdef HUB75_DIMMING_EN
        enable = 1'b0;
        n = 0;
        while (busy && n < 300) begin tick(); n++; end
        brightness = 8'd127;
        exp_run    = '{2, 4};
        enable     = 1'b1;
        measure_run(len);
        check_val("dim127_plane0", len, 2);
        measure_run(len);
        check_val("dim127_plane1", len, 4);
        enable = 1'b0;
        n = 0;
        while (busy && n < 300) begin tick(); n++; end
        brightness = 8'd0;
        exp_run    = '{1, 1};
        enable     = 1'b1;
        measure_run(len);
        check_val("dim0_plane0", len, 1);
        measure_run(len);
        check_val("dim0_plane1", len, 1);
`endif

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
